tile_renderer: RTL and testbench
================================

TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- BOARD_X0, 160, left pixel column of 4x4 board
- BOARD_Y0, 80, top pixel row of board
- TILE, 80, tile edge in pixels (board 320x320)
- BORDER, 4, tile border width in pixels
- RESET_BOARD, 16'h0660, board value after reset
REQ-002 SHALL have ports, one per line: name, direction, width, meaning (clock and reset first):
- dclk  in  1  pixel clock; sole clock
- clr  in  1  reset; synchronous, active-high
- hc  in  10  horizontal pixel count from VGA timing stage
- vc  in  10  vertical line count from VGA timing stage
- vidon  in  1  active-video flag from VGA timing stage
- btn_up, btn_down, btn_left, btn_right, btn_flip  in  1 each  debounced single-cycle command pulses
- load_board  in  1  load pulse
- load_value  in  16  board value for load
- red, green, blue  out  4 each  pixel colour to VGA output stage
- won  out  1  board is all-zero
- cursor_x, cursor_y  out  2 each  cursor tile coordinates
REQ-003 SHALL use one clock, dclk; reset clr is synchronous and active-high.

Function
REQ-010 Board bit index SHALL be y*4+x (x,y in 0..3); bit=1 means tile lit.
REQ-011 Command capture: single pending slot; a pulse SHALL be captured only when slot empty; later pulses while pending are dropped.
REQ-012 Simultaneous pulses in one cycle: priority flip > up > down > left > right; only the winner is captured.
REQ-013 Pending command SHALL be applied only in the cycle where hc==0 and vc==480 (first blanking line); slot clears on same edge.
REQ-014 Up/down/left/right SHALL move cursor by one tile with wrap (x=3 right -> 0, y=0 up -> 3).
REQ-015 Flip SHALL toggle bit at cursor plus orthogonal neighbours that exist; no wrap at edges (corner toggles 3 bits, edge 4, interior 5).
REQ-016 load_board SHALL set board=load_value, cursor=(0,0), clear pending slot on next edge; it overrides a same-cycle apply and any same-cycle capture.
REQ-017 won SHALL be registered: equals (board==0) one cycle after board updates.
REQ-018 Pixel path SHALL be a 2-stage pipeline: rgb reflects hc/vc/vidon sampled 2 dclk edges earlier.
REQ-019 Stage 1 SHALL register: vidon, in-board flag, tile x/y ((hc-BOARD_X0)/TILE etc.), border flag (pixel within BORDER of any tile edge); computations 10-bit unsigned, no negative wrap (hc<BOARD_X0 is out-of-board).
REQ-020 Stage 2 colour ({red,green,blue}, 12-bit) SHALL be: vidon=0 -> 000; out of board -> 222; border of cursor tile -> FFF; other border -> 0F0 if won else 888; interior bit=1 -> FF0; interior bit=0 -> 00F.
REQ-021 Board/cursor changes mid-frame (load only) SHALL be visible at next pixel sampled; command moves never change mid-frame.

Reset
REQ-030 On clr: board=RESET_BOARD, cursor=(0,0), pending slot empty, pipeline vidon cleared, rgb=000, won=(RESET_BOARD==0).
REQ-031 clr SHALL override load_board, capture and apply in the same cycle; pulses during clr are discarded.

Structure
REQ-040 Shared package vga_pkg SHALL hold H/V active sizes (640/480), apply line (480), 12-bit colour constants, command encoding type.
REQ-041 One sub-module board_state SHALL hold board, cursor, pending slot, won; tile_renderer holds the pixel pipeline.

Verification
REQ-050 Reset: clr 1 cycle -> board=0660, cursor=(0,0), won=0, rgb=000 next cycle.
REQ-051 Flip at (0,0) from 0000 via load -> board=0013 after apply line; at (1,1) from 0000 -> 0272.
REQ-052 btn_left at x=0 and btn_up at y=0 same cycle -> only up applied at vc=480,hc=0: cursor=(0,3).
REQ-053 load_board 16'h0013 then flip at (0,0) -> board=0000, won=1 one cycle later; board borders render 0F0.
REQ-054 Drive hc=165,vc=85,vidon=1, board bit0=1 -> FF0 border? no: 165-160=5>BORDER -> FF0 exactly 2 cycles later; hc=162 -> FFF (cursor tile); hc=100 -> 222; vidon=0 -> 000.
REQ-055 Pending flip plus load_board at apply cycle -> board=load_value, command lost, cursor=(0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA geometry, colour constants and the board command encoding
// for the tile puzzle renderer.
package vga_pkg;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned V_ACTIVE   = 480;
  localparam logic [9:0]  APPLY_LINE = 10'd480;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_BG     = 12'h222;
  localparam logic [11:0] COL_CURSOR = 12'hFFF;
  localparam logic [11:0] COL_WON    = 12'h0F0;
  localparam logic [11:0] COL_BORDER = 12'h888;
  localparam logic [11:0] COL_LIT    = 12'hFF0;
  localparam logic [11:0] COL_DARK   = 12'h00F;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_FLIP
  } cmd_e;

  // Tiles toggled by a flip at (x,y): the tile and its in-board orthogonal neighbours.
  function automatic logic [15:0] flip_mask(input logic [1:0] x, input logic [1:0] y);
    logic [15:0] m;
    logic [1:0]  xm, xp, ym, yp;
    m  = '0;
    xm = x - 2'd1;
    xp = x + 2'd1;
    ym = y - 2'd1;
    yp = y + 2'd1;
    m[{y, x}] = 1'b1;
    if (x != 2'd0) m[{y, xm}] = 1'b1;
    if (x != 2'd3) m[{y, xp}] = 1'b1;
    if (y != 2'd0) m[{ym, x}] = 1'b1;
    if (y != 2'd3) m[{yp, x}] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/board_state.sv
// Board, cursor and single-slot command queue; commands take effect only at
// the start of the first vertical blanking line so a frame never tears.
module board_state
  import vga_pkg::*;
#(
  parameter logic [15:0] RESET_BOARD = 16'h0660
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_hc,
  input  logic [9:0]  i_vc,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_btn_left,
  input  logic        i_btn_right,
  input  logic        i_btn_flip,
  input  logic        i_load,
  input  logic [15:0] i_load_value,
  output logic [15:0] o_board,
  output logic [1:0]  o_cx,
  output logic [1:0]  o_cy,
  output logic        o_won
);

  logic [15:0] r_board;
  logic [1:0]  r_cx;
  logic [1:0]  r_cy;
  cmd_e        r_pend;
  logic        r_won;

  cmd_e        w_cmd;
  logic        w_apply;

  always_comb begin
    w_cmd = CMD_NONE;
    if      (i_btn_flip)  w_cmd = CMD_FLIP;
    else if (i_btn_up)    w_cmd = CMD_UP;
    else if (i_btn_down)  w_cmd = CMD_DOWN;
    else if (i_btn_left)  w_cmd = CMD_LEFT;
    else if (i_btn_right) w_cmd = CMD_RIGHT;
  end

  assign w_apply = (r_pend != CMD_NONE) && (i_hc == '0) && (i_vc == APPLY_LINE);

  // Load beats apply beats capture; capture only sees an empty slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_board <= RESET_BOARD;
      r_cx    <= '0;
      r_cy    <= '0;
      r_pend  <= CMD_NONE;
      r_won   <= (RESET_BOARD == '0);
    end else begin
      r_won <= (r_board == '0);
      if (i_load) begin
        r_board <= i_load_value;
        r_cx    <= '0;
        r_cy    <= '0;
        r_pend  <= CMD_NONE;
      end else if (w_apply) begin
        r_pend <= CMD_NONE;
        case (r_pend)
          CMD_UP:    r_cy    <= r_cy - 2'd1;
          CMD_DOWN:  r_cy    <= r_cy + 2'd1;
          CMD_LEFT:  r_cx    <= r_cx - 2'd1;
          CMD_RIGHT: r_cx    <= r_cx + 2'd1;
          CMD_FLIP:  r_board <= r_board ^ flip_mask(r_cx, r_cy);
          default:   ;
        endcase
      end else if (r_pend == CMD_NONE) begin
        r_pend <= w_cmd;
      end
    end
  end

  assign o_board = r_board;
  assign o_cx    = r_cx;
  assign o_cy    = r_cy;
  assign o_won   = r_won;

endmodule

// File: rtl/tile_renderer.sv
// 4x4 lights-out board renderer: two-stage pixel pipeline (geometry, then
// colour) in front of the board_state game logic.
module tile_renderer
  import vga_pkg::*;
#(
  parameter int unsigned BOARD_X0    = 160,
  parameter int unsigned BOARD_Y0    = 80,
  parameter int unsigned TILE        = 80,
  parameter int unsigned BORDER      = 4,
  parameter logic [15:0] RESET_BOARD = 16'h0660
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        vidon,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_flip,
  input  logic        load_board,
  input  logic [15:0] load_value,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        won,
  output logic [1:0]  cursor_x,
  output logic [1:0]  cursor_y
);

  localparam logic [9:0] X0 = 10'(BOARD_X0);
  localparam logic [9:0] Y0 = 10'(BOARD_Y0);
  localparam logic [9:0] X1 = 10'(BOARD_X0 + 4 * TILE);
  localparam logic [9:0] Y1 = 10'(BOARD_Y0 + 4 * TILE);
  localparam logic [9:0] T1 = 10'(TILE);
  localparam logic [9:0] T2 = 10'(2 * TILE);
  localparam logic [9:0] T3 = 10'(3 * TILE);
  localparam logic [9:0] BW = 10'(BORDER);
  localparam logic [9:0] BF = 10'(TILE - BORDER);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);

  logic [15:0] w_board;
  logic [1:0]  w_cx, w_cy;
  logic        w_won;

  board_state #(.RESET_BOARD(RESET_BOARD)) u_board (
    .i_clk        (dclk),
    .i_rst        (clr),
    .i_hc         (hc),
    .i_vc         (vc),
    .i_btn_up     (btn_up),
    .i_btn_down   (btn_down),
    .i_btn_left   (btn_left),
    .i_btn_right  (btn_right),
    .i_btn_flip   (btn_flip),
    .i_load       (load_board),
    .i_load_value (load_value),
    .o_board      (w_board),
    .o_cx         (w_cx),
    .o_cy         (w_cy),
    .o_won        (w_won)
  );

  logic [9:0] w_dx, w_dy, w_ox, w_oy;
  logic [1:0] w_tx, w_ty;
  logic       w_in_board, w_border;

  assign w_dx = hc - X0;
  assign w_dy = vc - Y0;
  assign w_in_board = (hc >= X0) && (hc < X1) && (vc >= Y0) && (vc < Y1)
                   && (hc < HA) && (vc < VA);

  // Tile index by comparison against multiples of TILE instead of a divider.
  always_comb begin
    w_tx = 2'd0;
    w_ox = w_dx;
    if      (w_dx >= T3) begin w_tx = 2'd3; w_ox = w_dx - T3; end
    else if (w_dx >= T2) begin w_tx = 2'd2; w_ox = w_dx - T2; end
    else if (w_dx >= T1) begin w_tx = 2'd1; w_ox = w_dx - T1; end
    w_ty = 2'd0;
    w_oy = w_dy;
    if      (w_dy >= T3) begin w_ty = 2'd3; w_oy = w_dy - T3; end
    else if (w_dy >= T2) begin w_ty = 2'd2; w_oy = w_dy - T2; end
    else if (w_dy >= T1) begin w_ty = 2'd1; w_oy = w_dy - T1; end
    w_border = (w_ox < BW) || (w_ox >= BF) || (w_oy < BW) || (w_oy >= BF);
  end

  logic       r_s1_vidon, r_s1_in_board, r_s1_border;
  logic [1:0] r_s1_tx, r_s1_ty;

  always_ff @(posedge dclk) begin
    if (clr) begin
      r_s1_vidon    <= 1'b0;
      r_s1_in_board <= 1'b0;
      r_s1_border   <= 1'b0;
      r_s1_tx       <= '0;
      r_s1_ty       <= '0;
    end else begin
      r_s1_vidon    <= vidon;
      r_s1_in_board <= w_in_board;
      r_s1_border   <= w_border;
      r_s1_tx       <= w_tx;
      r_s1_ty       <= w_ty;
    end
  end

  logic [11:0] w_colour;
  logic [11:0] r_rgb;
  logic        w_bit, w_is_cursor;

  assign w_bit       = w_board[{r_s1_ty, r_s1_tx}];
  assign w_is_cursor = (r_s1_tx == w_cx) && (r_s1_ty == w_cy);

  always_comb begin
    w_colour = COL_BLACK;
    if (!r_s1_vidon)        w_colour = COL_BLACK;
    else if (!r_s1_in_board) w_colour = COL_BG;
    else if (r_s1_border)   w_colour = w_is_cursor ? COL_CURSOR : (w_won ? COL_WON : COL_BORDER);
    else                    w_colour = w_bit ? COL_LIT : COL_DARK;
  end

  always_ff @(posedge dclk) begin
    if (clr) r_rgb <= '0;
    else     r_rgb <= w_colour;
  end

  assign red      = r_rgb[11:8];
  assign green    = r_rgb[7:4];
  assign blue     = r_rgb[3:0];
  assign won      = w_won;
  assign cursor_x = w_cx;
  assign cursor_y = w_cy;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: board contents are read back through the
// rendered tile interiors, cursor and won through their ports.
module tb_tile_renderer;

  localparam int X0 = 160;
  localparam int Y0 = 80;
  localparam int T  = 80;

  logic        dclk = 1'b0;
  logic        clr;
  logic [9:0]  hc, vc;
  logic        vidon;
  logic        btn_up, btn_down, btn_left, btn_right, btn_flip;
  logic        load_board;
  logic [15:0] load_value;
  logic [3:0]  red, green, blue;
  logic        won;
  logic [1:0]  cursor_x, cursor_y;

  int checks = 0;
  int errors = 0;

  tile_renderer #(
    .BOARD_X0(160), .BOARD_Y0(80), .TILE(80), .BORDER(4), .RESET_BOARD(16'h0660)
  ) dut (
    .dclk(dclk), .clr(clr), .hc(hc), .vc(vc), .vidon(vidon),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_flip(btn_flip),
    .load_board(load_board), .load_value(load_value),
    .red(red), .green(green), .blue(blue), .won(won),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 dclk = ~dclk;

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic park();
    hc = 10'd700; vc = 10'd10; vidon = 1'b0;
  endtask

  task automatic apply_line();
    hc = 10'd0; vc = 10'd480; vidon = 1'b0;
    tick();
    park();
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic f);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_flip = f;
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_flip = 0;
  endtask

  task automatic load(input logic [15:0] v);
    load_board = 1'b1; load_value = v;
    tick();
    load_board = 1'b0;
  endtask

  task automatic pix(input int h, input int v, input logic on);
    hc = 10'(h); vc = 10'(v); vidon = on;
    tick();
    tick();
  endtask

  task automatic read_board(output logic [15:0] b);
    b = '0;
    for (int i = 0; i < 16; i++) begin
      pix(X0 + (i % 4) * T + 40, Y0 + (i / 4) * T + 40, 1'b1);
      b[i] = ({red, green, blue} == 12'hFF0);
    end
    park();
  endtask

  task automatic test_reset();
    logic [15:0] b;
    clr = 1'b1; vidon = 1'b1; hc = 10'd200; vc = 10'd100;
    tick();
    clr = 1'b0; park();
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb got %h want 000", {red, green, blue});
    end
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0000) begin
      errors++; $display("FAIL reset_cursor got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
    checks++;
    if (won !== 1'b0) begin
      errors++; $display("FAIL reset_won got %b want 0", won);
    end
    read_board(b);
    checks++;
    if (b !== 16'h0660) begin
      errors++; $display("FAIL reset_board got %h want 0660", b);
    end
  endtask

  task automatic test_flip();
    logic [15:0] b;
    load(16'h0000);
    pulse(0, 0, 0, 0, 1);
    read_board(b);
    checks++;
    if (b !== 16'h0000) begin
      errors++; $display("FAIL flip_before_apply got %h want 0000", b);
    end
    apply_line();
    read_board(b);
    checks++;
    if (b !== 16'h0013) begin
      errors++; $display("FAIL flip_corner got %h want 0013", b);
    end
    load(16'h0000);
    pulse(0, 0, 0, 1, 0); apply_line();
    pulse(0, 1, 0, 0, 0); apply_line();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0101) begin
      errors++; $display("FAIL move_to_11 got (%0d,%0d) want (1,1)", cursor_x, cursor_y);
    end
    pulse(0, 0, 0, 0, 1); apply_line();
    read_board(b);
    checks++;
    if (b !== 16'h0272) begin
      errors++; $display("FAIL flip_interior got %h want 0272", b);
    end
  endtask

  task automatic test_priority_wrap();
    load(16'h0000);
    pulse(1, 0, 1, 0, 0);
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0000) begin
      errors++; $display("FAIL prio_before_apply got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
    apply_line();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0011) begin
      errors++; $display("FAIL prio_up_wins got (%0d,%0d) want (0,3)", cursor_x, cursor_y);
    end
    pulse(0, 0, 1, 0, 0); apply_line();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b1111) begin
      errors++; $display("FAIL wrap_left got (%0d,%0d) want (3,3)", cursor_x, cursor_y);
    end
    pulse(0, 0, 0, 1, 0); apply_line();
    pulse(0, 1, 0, 0, 0); apply_line();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0000) begin
      errors++; $display("FAIL wrap_right_down got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_drop();
    load(16'h0000);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    apply_line();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0011) begin
      errors++; $display("FAIL drop_first_kept got (%0d,%0d) want (0,3)", cursor_x, cursor_y);
    end
    apply_line();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0011) begin
      errors++; $display("FAIL drop_second_lost got (%0d,%0d) want (0,3)", cursor_x, cursor_y);
    end
  endtask

  task automatic test_pixels();
    load(16'h0013);
    pix(165, 85, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'hFF0) begin
      errors++; $display("FAIL pix_interior_lit got %h want FF0", {red, green, blue});
    end
    hc = 10'd100;
    tick();
    checks++;
    if ({red, green, blue} !== 12'hFF0) begin
      errors++; $display("FAIL pix_latency got %h want FF0", {red, green, blue});
    end
    tick();
    checks++;
    if ({red, green, blue} !== 12'h222) begin
      errors++; $display("FAIL pix_outside got %h want 222", {red, green, blue});
    end
    pix(162, 85, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      errors++; $display("FAIL pix_cursor_border got %h want FFF", {red, green, blue});
    end
    pix(241, 85, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'h888) begin
      errors++; $display("FAIL pix_border got %h want 888", {red, green, blue});
    end
    pix(360, 120, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'h00F) begin
      errors++; $display("FAIL pix_interior_dark got %h want 00F", {red, green, blue});
    end
    pix(479, 385, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'h888) begin
      errors++; $display("FAIL pix_last_col got %h want 888", {red, green, blue});
    end
    pix(480, 385, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'h222) begin
      errors++; $display("FAIL pix_right_edge got %h want 222", {red, green, blue});
    end
    pix(165, 85, 1'b0);
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL pix_blank got %h want 000", {red, green, blue});
    end
    park();
  endtask

  task automatic test_won();
    load(16'h0013);
    tick();
    checks++;
    if (won !== 1'b0) begin
      errors++; $display("FAIL won_nonzero got %b want 0", won);
    end
    pulse(0, 0, 0, 0, 1);
    apply_line();
    checks++;
    if (won !== 1'b0) begin
      errors++; $display("FAIL won_registered got %b want 0", won);
    end
    tick();
    checks++;
    if (won !== 1'b1) begin
      errors++; $display("FAIL won_set got %b want 1", won);
    end
    pix(241, 85, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      errors++; $display("FAIL won_border got %h want 0F0", {red, green, blue});
    end
    pix(162, 85, 1'b1);
    checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      errors++; $display("FAIL won_cursor_border got %h want FFF", {red, green, blue});
    end
    park();
  endtask

  task automatic test_load_at_apply();
    logic [15:0] b;
    load(16'h0000);
    pulse(0, 0, 0, 1, 0); apply_line();
    pulse(0, 0, 0, 0, 1);
    hc = 10'd0; vc = 10'd480;
    load_board = 1'b1; load_value = 16'hA5A5;
    tick();
    load_board = 1'b0; park();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0000) begin
      errors++; $display("FAIL load_apply_cursor got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
    apply_line();
    read_board(b);
    checks++;
    if (b !== 16'hA5A5) begin
      errors++; $display("FAIL load_apply_board got %h want A5A5", b);
    end
  endtask

  task automatic test_clr_override();
    logic [15:0] b;
    clr = 1'b1; load_board = 1'b1; load_value = 16'hFFFF; btn_right = 1'b1;
    tick();
    clr = 1'b0; load_board = 1'b0; btn_right = 1'b0;
    apply_line();
    checks++;
    if ({cursor_x, cursor_y} !== 4'b0000) begin
      errors++; $display("FAIL clr_cursor got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
    read_board(b);
    checks++;
    if (b !== 16'h0660) begin
      errors++; $display("FAIL clr_board got %h want 0660", b);
    end
  endtask

  initial begin
    clr = 1'b0; load_board = 1'b0; load_value = '0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_flip = 0;
    park();
    test_reset();
    test_flip();
    test_priority_wrap();
    test_drop();
    test_pixels();
    test_won();
    test_load_at_apply();
    test_clr_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
